// File: rtl/tcp_pkg.sv
// rtl/tcp_pkg.sv - shared TCP flag constants, segment field positions and arbiter state type
package tcp_pkg;

  localparam int SEG_W = 32;
  localparam int SEG_FLAGS_MSB = 31;
  localparam int SEG_FLAGS_LSB = 24;
  localparam int SEG_SEQ_MSB = 23;
  localparam int SEG_SEQ_LSB = 0;

  localparam logic [7:0] FLAG_FIN    = 8'h01;
  localparam logic [7:0] FLAG_SYN    = 8'h02;
  localparam logic [7:0] FLAG_ACK    = 8'h10;
  localparam logic [7:0] FLAG_SYNACK = 8'h12;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/tcp_rr_arbiter.sv
// rtl/tcp_rr_arbiter.sv - combinational round-robin pick: first request at or after ptr, wrapping
module tcp_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/tcp_conn_scheduler.sv
// rtl/tcp_conn_scheduler.sv - maps ingress segments to connection engine slots and
// round-robin merges engine transmit requests onto one egress port
module tcp_conn_scheduler
  import tcp_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int CONN_ID_W = 16,
  parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rx_valid,
  input  logic [SEG_W-1:0]           rx_data,
  input  logic [CONN_ID_W-1:0]       rx_conn_id,
  output logic [NUM_SLOTS-1:0]       slot_rx_valid,
  output logic [SEG_W-1:0]           slot_rx_data,
  input  logic [NUM_SLOTS-1:0]       slot_close,
  input  logic [NUM_SLOTS-1:0]       slot_tx_valid,
  input  logic [SEG_W*NUM_SLOTS-1:0] slot_tx_data,
  output logic [NUM_SLOTS-1:0]       slot_tx_grant,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [SEG_W-1:0]           tx_data,
  output logic [CONN_ID_W-1:0]       tx_conn_id,
  output logic                       rx_drop,
  output logic [SLOT_W:0]            active_count
);

  localparam logic [NUM_SLOTS-1:0] ONE_HOT_0 = {{(NUM_SLOTS-1){1'b0}}, 1'b1};

  logic [NUM_SLOTS-1:0] valid_q;
  logic [CONN_ID_W-1:0] conn_id_q [NUM_SLOTS];

  logic                 hit_any;
  logic [SLOT_W-1:0]    hit_idx;
  logic                 free_any;
  logic [SLOT_W-1:0]    free_idx;
  logic                 is_syn;
  logic                 do_alloc;
  logic [NUM_SLOTS-1:0] valid_next;
  logic [SLOT_W:0]      count_next;

  arb_state_t           state;
  logic [SLOT_W-1:0]    rr_ptr;
  logic [SLOT_W-1:0]    gnt_idx;
  logic [NUM_SLOTS-1:0] arb_grant;
  logic [SLOT_W-1:0]    arb_idx;
  logic                 arb_any;

  // Descending scan leaves the lowest matching / lowest free index.
  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (valid_q[i] && (conn_id_q[i] == rx_conn_id)) begin
        hit_any = 1'b1;
        hit_idx = SLOT_W'(i);
      end
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = SLOT_W'(i);
      end
    end
  end

  assign is_syn   = (rx_data[SEG_FLAGS_MSB:SEG_FLAGS_LSB] == FLAG_SYN);
  assign do_alloc = rx_valid && !hit_any && is_syn && free_any;

  // Close acts on the pre-close table; an allocation only ever targets an invalid slot.
  always_comb begin
    valid_next = valid_q & ~slot_close;
    if (do_alloc) valid_next[free_idx] = 1'b1;
    count_next = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      count_next = count_next + {{SLOT_W{1'b0}}, valid_next[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '0;
      active_count  <= '0;
      slot_rx_valid <= '0;
      slot_rx_data  <= '0;
      rx_drop       <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) conn_id_q[i] <= '0;
    end else begin
      valid_q       <= valid_next;
      active_count  <= count_next;
      slot_rx_valid <= '0;
      rx_drop       <= 1'b0;
      if (do_alloc) conn_id_q[free_idx] <= rx_conn_id;
      if (rx_valid) begin
        if (hit_any) begin
          slot_rx_valid <= ONE_HOT_0 << hit_idx;
          slot_rx_data  <= rx_data;
        end else if (do_alloc) begin
          slot_rx_valid <= ONE_HOT_0 << free_idx;
          slot_rx_data  <= rx_data;
        end else begin
          rx_drop <= 1'b1;
        end
      end
    end
  end

  tcp_rr_arbiter #(
    .N     (NUM_SLOTS),
    .IDX_W (SLOT_W)
  ) u_arb (
    .req   (slot_tx_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // The grant pulse coincides with tx_valid rising, so the engine may advance right away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ARB_IDLE;
      rr_ptr        <= '0;
      gnt_idx       <= '0;
      tx_valid      <= 1'b0;
      tx_data       <= '0;
      tx_conn_id    <= '0;
      slot_tx_grant <= '0;
    end else begin
      slot_tx_grant <= '0;
      case (state)
        ARB_IDLE: begin
          if (arb_any) begin
            tx_valid      <= 1'b1;
            tx_data       <= slot_tx_data[SEG_W*arb_idx +: SEG_W];
            tx_conn_id    <= valid_q[arb_idx] ? conn_id_q[arb_idx] : '0;
            slot_tx_grant <= arb_grant;
            gnt_idx       <= arb_idx;
            state         <= ARB_HOLD;
          end
        end
        ARB_HOLD: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            rr_ptr   <= (gnt_idx == SLOT_W'(NUM_SLOTS - 1)) ? '0 : gnt_idx + 1'b1;
            state    <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
